// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the controller state encoding and operation select codes.
package alu_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SEL_W = 2;

  localparam int SEL_ADD = 0;
  localparam int SEL_SUB = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_arith.sv
// Signed add/subtract unit with overflow detection.
// Works one bit wider so the carry-out exposes signed overflow.
module arithmetic_unit
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] Q,
  output logic             overflow
);

  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;
  logic [WIDTH:0] r;

  always_comb begin
    ax = {A[WIDTH-1], A};
    bx = {B[WIDTH-1], B};
    r  = '0;
    case (sel)
      SEL_W'(SEL_ADD): r = ax + bx;
      SEL_W'(SEL_SUB): r = ax - bx;
      default:         r = ax + bx;
    endcase
  end

  // Sign bits disagree only when the true result left the range.
  assign Q        = r[WIDTH-1:0];
  assign overflow = r[WIDTH] ^ r[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one arithmetic unit between two requesters.
// One operation in flight: accept, execute for a cycle, hold the response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_ov
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ov_q, ov_d;
  logic             rid_q, rid_d;

  logic             gnt;
  logic             idle_ok;
  logic             hs;
  logic [WIDTH-1:0] au_q;
  logic             au_ov;

  // prio_q == 1 means requester 1 currently wins a tie.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = prio_q;
    end else begin
      gnt = req1_valid;
    end
  end

  assign idle_ok    = (state_q == S_IDLE) && !rst;
  assign req0_ready = idle_ok && req0_valid && !gnt;
  assign req1_ready = idle_ok && req1_valid && gnt;
  assign hs         = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    id_d    = id_q;
    res_d   = res_q;
    ov_d    = ov_q;
    rid_d   = rid_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = S_EXEC;
          prio_d  = !gnt;
          id_d    = gnt;
          a_d     = gnt ? req1_a : req0_a;
          b_d     = gnt ? req1_b : req0_b;
          sel_d   = gnt ? req1_sel : req0_sel;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        res_d   = au_q;
        ov_d    = au_ov;
        rid_d   = id_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      rid_q   <= rid_d;
    end
  end

  arithmetic_unit #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_au (
    .A        (a_q),
    .B        (b_q),
    .sel      (sel_q),
    .Q        (au_q),
    .overflow (au_ov)
  );

  // A pending response is suppressed while reset is held.
  assign rsp_valid = (state_q == S_RESP) && !rst;
  assign rsp_id    = rid_q;
  assign rsp_q     = res_q;
  assign rsp_ov    = ov_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the signed operand and result width.
REQ-002 The block SHALL have parameter SEL_W, default 2, giving the operation-select width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reqN_valid  input  1  request valid from requester N (N = 0, 1).
REQ-006 reqN_ready  output  1  requester N's request is accepted this cycle.
REQ-007 reqN_a, reqN_b  input  WIDTH  signed operands from requester N.
REQ-008 reqN_sel  input  SEL_W  operation select from requester N.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_q  output  WIDTH  signed result.
REQ-013 rsp_ov  output  1  signed overflow flag of the result.

Function
REQ-014 The block SHALL share one arithmetic_unit instance between two requesters, with sel 0 = A+B and sel 1 = A-B.
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 IDLE->EXEC SHALL occur on a handshake; EXEC->RESP SHALL occur unconditionally after one cycle; RESP->IDLE SHALL occur when rsp_valid && rsp_ready.
REQ-017 A handshake SHALL be reqN_valid && reqN_ready in the same cycle, and SHALL capture a, b, sel and id into internal registers.
REQ-018 reqN_ready SHALL be combinational and high only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-019 Arbitration SHALL be round-robin: the most recently granted requester gets lowest priority, and the priority pointer SHALL update only on a handshake.
REQ-020 With a single valid requester, that requester SHALL be granted regardless of the pointer.
REQ-021 During EXEC, the captured operands SHALL drive arithmetic_unit, and Q/overflow SHALL be registered into rsp_q/rsp_ov at the end of EXEC.
REQ-022 Latency SHALL be a handshake in cycle N giving rsp_valid high in cycle N+2.
REQ-023 In RESP, rsp_valid, rsp_id, rsp_q and rsp_ov SHALL be held stable until accepted.
REQ-024 No new request SHALL be accepted before the block returns to IDLE; a response accepted in cycle M SHALL allow the earliest next handshake in cycle M+1.
REQ-025 Requesters SHALL hold valid and operands stable while valid && !ready; the block SHALL NOT sample uncaptured inputs.
REQ-026 rsp_ov SHALL be 1 exactly when the true signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], with rsp_q equal to the wrapped WIDTH-bit result.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and the priority pointer SHALL favour requester 0.
REQ-028 On rst, rsp_valid, rsp_id, rsp_q and rsp_ov SHALL all be 0.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the operation, with no response emitted and no ready asserted during reset cycles.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the SEL_ADD=0 and SEL_SUB=1 constants, and the default WIDTH.
REQ-031 arithmetic_unit SHALL be the single instantiated sub-module (ports A, B, sel, Q, overflow); arbitration and the FSM SHALL stay in alu_arbiter.

Verification
REQ-032 After reset, req0 a=3 b=2 sel=0 -> req0_ready in the accept cycle; rsp_valid two cycles later with q=5, ov=0, id=0.
REQ-033 req1 a=7 b=1 sel=0 -> q=-8, ov=1, id=1; then req1 a=-8 b=1 sel=1 -> q=7, ov=1.
REQ-034 Both requesters valid in the first cycle after reset (req0 a=1 b=1 sel=0; req1 a=2 b=2 sel=0) with rsp_ready=1 -> req0 served first (q=2), then req1 (q=4), alternating while both remain valid.
REQ-035 rsp_ready held low 3 cycles in RESP -> rsp_* stable and both readys low throughout; accept on the 4th cycle; next handshake one cycle later.
REQ-036 rst pulsed in EXEC -> rsp_valid never rises for that request; the next simultaneous request grants req0.
